pattern_match_controller: RTL and testbench
===========================================

// Module: pattern_match_controller
// PURPOSE
//  Programmable serial-pattern detection session controller. Holds a loaded pattern, runs bounded detection
//  sessions over a bit stream, emits per-match pulses, counts matches and signals completion. Configures and
//  sequences the serial detection path between the stimulus/bit source and the status/interrupt logic.
// PARAMETERS
//  PAT_W  4  maximum pattern length in bits (>=2)
//  LEN_W  8  width of session bit-count field
//  CNT_W  8  width of match counter
// PORTS
//  CLK          in   1          clock, rising edge
//  RST          in   1          asynchronous, active-low reset
//  cfg_valid    in   1          config offer; accepted when cfg_valid && cfg_ready
//  cfg_ready    out  1          1 in every state except RUN
//  cfg_pattern  in   PAT_W      pattern; pat[len-1] is the first bit received in time, pat[0] the last
//  cfg_len      in   $clog2(PAT_W)+1  pattern length; 0 is treated as 1, >PAT_W is treated as PAT_W
//  cfg_bits     in   LEN_W      number of stream bits in one session
//  start        in   1          begin a session (honoured in READY or DONE only)
//  bit_valid    in   1          Binary_In qualifier, 1 bit per qualified cycle
//  Binary_In    in   1          serial data
//  busy         out  1          1 in RUN
//  match_pulse  out  1          1-cycle pulse per detected match (overlapping matches allowed)
//  match_count  out  CNT_W      matches in current/last session; saturates
//  overflow     out  1          sticky: count saturated this session
//  done         out  1          level, 1 in DONE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cfg_ready=1; stored config, history, counters cleared.
//  FSM: IDLE -(cfg accept)-> READY; READY/DONE -(cfg accept)-> READY; READY/DONE -(start)-> RUN;
//       RUN -(remaining reaches 0)-> DONE. start in IDLE is ignored.
//  Same-cycle cfg accept and start: the config is captured, start is ignored, next state is READY.
//  On start: match_count=0, overflow=0, history=0, fill=0, remaining=cfg_bits. If cfg_bits==0, RUN lasts
//   exactly 1 cycle, then DONE with count 0.
//  RUN, each bit_valid: hist <= {hist[PAT_W-2:0],Binary_In}; fill++ (saturating at PAT_W); remaining--.
//   Match = (new fill >= len) && (new hist[len-1:0] == pat[len-1:0]).
//   match_pulse is registered: high the cycle after the completing bit_valid cycle (latency 1).
//   match_count increments on the same edge as match_pulse.
//  Final bit: a match on the last bit is counted. DONE is entered on the same edge as that pulse.
//  bit_valid outside RUN: ignored; no history update.
//  Saturation: count==2^CNT_W-1 plus a further match -> count holds, overflow=1; match_pulse still fires.
//  busy=1 only in RUN. done=1 only in DONE. Count and overflow hold in DONE until the next start.
//  Reset mid-session: immediate return to IDLE; config is lost; no done.
// CONFIGURATION
//  PMC_MATCH_LIMIT_EN defined: adds input cfg_limit[CNT_W-1:0], captured with the config.
//   Nonzero limit: the session ends early (RUN->DONE) on the edge where match_count becomes cfg_limit.
//   Further bit_valid is ignored. limit 0 = no limit.
//  PMC_MATCH_LIMIT_EN undefined: port absent; sessions end only on bit exhaustion.
// STRUCTURE
//  pmc_pkg: state enum {IDLE,READY,RUN,DONE} (2-bit); default PAT_W/LEN_W/CNT_W localparams;
//   helper function clamp_len().
//  Sub-module pmc_shift_matcher: history shift register, fill counter and masked compare (combinational match
//   out). The top holds the FSM, config registers, remaining counter, match counter and flags.
// TESTING
//  1 Reset mid-RUN -> IDLE next cycle; all outputs 0; cfg_ready=1; start then ignored until a new config.
//  2 pat=4'b1011, len=4, bits=7, stream 1,0,1,1,0,1,1 -> match_pulse after bits 4 and 7; count=2;
//    done on the cycle after bit 7.
//  3 pat=2'b11, len=2, bits=5, stream 1,1,1,1,1 -> 4 overlapping pulses; count=4; gaps in bit_valid do not
//    alter the result.
//  4 CNT_W=2, pat=1, len=1, bits=6, all ones -> count holds at 3; overflow=1; 6 pulses.
//  5 bits=0 start -> busy for 1 cycle, then done=1 with count=0; cfg+start in the same cycle -> READY,
//    no session.
//  6 (PMC_MATCH_LIMIT_EN) limit=2, test 3 stream -> DONE after 2nd pulse; count=2; remaining bits ignored.

Source files
------------

// File: rtl/pmc_pkg.sv
// -----------------------------------------------------------------------------
// pmc_pkg
// Shared types and defaults for the pattern_match_controller slice.
//   state_t       : session FSM encoding (IDLE, READY, RUN, DONE), 2 bits
//   *_DEFAULT     : default PAT_W / LEN_W / CNT_W parameter values
//   clamp_len()   : maps a raw pattern length onto the legal range 1..pat_w
// -----------------------------------------------------------------------------
package pmc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PAT_W_DEFAULT = 4;
    localparam int LEN_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 8;

    // A length of 0 means a single-bit pattern; anything longer than the
    // history register is cut down to the full register width.
    function automatic int clamp_len(input int len, input int pat_w);
        if (len < 1)
            return 1;
        else if (len > pat_w)
            return pat_w;
        else
            return len;
    endfunction

endpackage

// File: rtl/pattern_match_controller_shift_matcher.sv
// -----------------------------------------------------------------------------
// pmc_shift_matcher
// Serial history register with fill tracking and a length-masked compare.
// The match output looks at the values the registers are about to take, so a
// registered copy of it lines up with the edge that shifts in the last bit.
// Ports:
//   CLK, RST  : clock, asynchronous active-low reset
//   clear     : zero history and fill (session start)
//   shift     : shift din into the history this cycle
//   din       : serial data bit
//   pattern   : pattern, bit [len-1] oldest, bit [0] newest
//   len       : already-clamped pattern length (1..PAT_W)
//   match     : combinational, 1 when this shift completes a match
// -----------------------------------------------------------------------------
module pmc_shift_matcher #(
    parameter  int PAT_W = 4,
    localparam int LW    = $clog2(PAT_W) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             match
);

    logic [PAT_W-1:0] hist;
    logic [LW-1:0]    fill;
    logic [PAT_W-1:0] next_hist;
    logic [LW-1:0]    next_fill;
    logic [PAT_W-1:0] mask;

    assign next_hist = {hist[PAT_W-2:0], din};
    assign next_fill = (fill == LW'(PAT_W)) ? fill : fill + 1'b1;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (LW'(i) < len);
    end

    assign match = shift && (next_fill >= len) &&
                   ((next_hist & mask) == (pattern & mask));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= next_hist;
            fill <= next_fill;
        end
    end

endmodule

// File: rtl/pattern_match_controller.sv
// -----------------------------------------------------------------------------
// pattern_match_controller
// Serial-pattern detection session controller: holds a loaded pattern, runs
// bounded sessions over a bit stream, pulses per match, counts matches
// (saturating with a sticky overflow flag) and flags completion.
// Optional feature macro: PMC_MATCH_LIMIT_EN adds cfg_limit, a match count at
// which the session ends early (0 = no limit).
// Ports:
//   CLK, RST      : clock (rising), asynchronous active-low reset
//   cfg_valid/ready, cfg_pattern, cfg_len, cfg_bits [, cfg_limit] : config
//   start         : begin a session (READY or DONE only)
//   bit_valid, Binary_In : qualified serial data
//   busy, done    : 1 in RUN / 1 in DONE
//   match_pulse   : one-cycle pulse per match
//   match_count, overflow : session match count and saturation flag
// -----------------------------------------------------------------------------
module pattern_match_controller
    import pmc_pkg::*;
#(
    parameter  int PAT_W = PAT_W_DEFAULT,
    parameter  int LEN_W = LEN_W_DEFAULT,
    parameter  int CNT_W = CNT_W_DEFAULT,
    localparam int LW    = $clog2(PAT_W) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LW-1:0]    cfg_len,
    input  logic [LEN_W-1:0] cfg_bits,
`ifdef PMC_MATCH_LIMIT_EN
    input  logic [CNT_W-1:0] cfg_limit,
`endif
    input  logic             start,
    input  logic             bit_valid,
    input  logic             Binary_In,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic             done
);

    state_t           state;
    state_t           next_state;
    logic [PAT_W-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic [LEN_W-1:0] bits_q;
    logic [LEN_W-1:0] remaining;
    logic             cfg_accept;
    logic             start_ok;
    logic             shift;
    logic             match;
    logic             count_full;
    logic [CNT_W-1:0] next_count;
    logic             limit_hit;

    assign cfg_accept = cfg_valid && cfg_ready;
    // A config offered together with start wins; the start is dropped.
    assign start_ok   = start && !cfg_accept && (state == READY || state == DONE);
    // remaining is only 0 in RUN for a zero-length session, which takes no bits.
    assign shift      = (state == RUN) && bit_valid && (remaining != '0);
    assign count_full = (match_count == {CNT_W{1'b1}});
    assign next_count = count_full ? match_count : match_count + 1'b1;

`ifdef PMC_MATCH_LIMIT_EN
    logic [CNT_W-1:0] limit_q;
    assign limit_hit = match && (limit_q != '0) && (next_count == limit_q);
`else
    assign limit_hit = 1'b0;
`endif

    pmc_shift_matcher #(.PAT_W(PAT_W)) u_matcher (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (start_ok),
        .shift   (shift),
        .din     (Binary_In),
        .pattern (pat_q),
        .len     (len_q),
        .match   (match)
    );

    // FSM: state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    // FSM: next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:        if (cfg_accept) next_state = READY;
            READY, DONE: if (cfg_accept)    next_state = READY;
                         else if (start_ok) next_state = RUN;
            RUN:         if ((remaining == '0) ||
                             (shift && remaining == LEN_W'(1)) ||
                             limit_hit)
                             next_state = DONE;
            default:     next_state = IDLE;
        endcase
    end

    // FSM: state-decoded outputs
    always_comb begin
        cfg_ready = (state != RUN);
        busy      = (state == RUN);
        done      = (state == DONE);
    end

    // Config, session counters and match reporting
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pat_q       <= '0;
            len_q       <= '0;
            bits_q      <= '0;
            remaining   <= '0;
            match_pulse <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            match_pulse <= match;
            if (cfg_accept) begin
                pat_q  <= cfg_pattern;
                len_q  <= LW'(clamp_len(int'(cfg_len), PAT_W));
                bits_q <= cfg_bits;
            end
            if (start_ok) begin
                remaining   <= bits_q;
                match_count <= '0;
                overflow    <= 1'b0;
            end else begin
                if (shift)
                    remaining <= remaining - 1'b1;
                if (match) begin
                    match_count <= next_count;
                    if (count_full)
                        overflow <= 1'b1;
                end
            end
        end
    end

`ifdef PMC_MATCH_LIMIT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)            limit_q <= '0;
        else if (cfg_accept) limit_q <= cfg_limit;
    end
`endif

endmodule

// File: tb/tb_pattern_match_controller.sv
// -----------------------------------------------------------------------------
// tb_pattern_match_controller
// Drives two controllers from the same stimulus: one with default widths and
// one with CNT_W=2 to reach count saturation quickly. Expected per-bit results
// come from a behavioural model, are pushed to a scoreboard when a bit is
// driven, and are popped and compared once the DUT has registered that bit.
// Define PMC_MATCH_LIMIT_EN to include the match-limit scenario.
// -----------------------------------------------------------------------------
module tb_pattern_match_controller;
    import pmc_pkg::*;

    localparam int PAT_W = 4;
    localparam int LEN_W = 8;
    localparam int CNT_W = 8;
    localparam int SAT_W = 2;
    localparam int LW    = $clog2(PAT_W) + 1;
    localparam int MAX_M = (1 << CNT_W) - 1;
    localparam int MAX_S = (1 << SAT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LW-1:0]    cfg_len = '0;
    logic [LEN_W-1:0] cfg_bits = '0;
    logic [CNT_W-1:0] cfg_limit = '0;
    logic             start = 1'b0;
    logic             bit_valid = 1'b0;
    logic             Binary_In = 1'b0;

    logic             cfg_ready, busy, match_pulse, overflow, done;
    logic [CNT_W-1:0] match_count;
    logic             s_cfg_ready, s_busy, s_match_pulse, s_overflow, s_done;
    logic [SAT_W-1:0] s_match_count;

    always #5 CLK = ~CLK;

    pattern_match_controller #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_bits(cfg_bits),
`ifdef PMC_MATCH_LIMIT_EN
        .cfg_limit(cfg_limit),
`endif
        .start(start), .bit_valid(bit_valid), .Binary_In(Binary_In),
        .busy(busy), .match_pulse(match_pulse), .match_count(match_count),
        .overflow(overflow), .done(done)
    );

    pattern_match_controller #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(SAT_W)) dut_sat (
        .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_bits(cfg_bits),
`ifdef PMC_MATCH_LIMIT_EN
        .cfg_limit(cfg_limit[SAT_W-1:0]),
`endif
        .start(start), .bit_valid(bit_valid), .Binary_In(Binary_In),
        .busy(s_busy), .match_pulse(s_match_pulse), .match_count(s_match_count),
        .overflow(s_overflow), .done(s_done)
    );

    typedef struct {
        logic pulse;
        int   count;
        logic ovf;
        int   sat_count;
        logic sat_ovf;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // behavioural model state
    int m_pat, m_len, m_bits, m_limit;
    int m_hist, m_fill, m_rem, m_count, m_sat_count;
    bit m_ovf, m_sat_ovf, m_active, m_done;

    task automatic do_cfg(input int pat, input int len, input int bits, input int limit);
        @(negedge CLK);
        cfg_valid   = 1'b1;
        cfg_pattern = PAT_W'(pat);
        cfg_len     = LW'(len);
        cfg_bits    = LEN_W'(bits);
        cfg_limit   = CNT_W'(limit);
        m_pat  = pat;
        m_len  = (len == 0) ? 1 : (len > PAT_W) ? PAT_W : len;
        m_bits = bits;
`ifdef PMC_MATCH_LIMIT_EN
        m_limit = limit;
`else
        m_limit = 0;
`endif
        m_active = 1'b0;
        m_done   = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ready_state: ready=%b busy=%b done=%b required 1 0 0", cfg_ready, busy, done);
        end
    endtask

    task automatic start_session();
        start = 1'b1;
        m_hist = 0; m_fill = 0; m_rem = m_bits;
        m_count = 0; m_sat_count = 0; m_ovf = 1'b0; m_sat_ovf = 1'b0;
        m_active = 1'b1; m_done = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || match_count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL session_start: busy=%b count=%0d ovf=%b required 1 0 0", busy, match_count, overflow);
        end
    endtask

    // Drive one cycle of the bit stream, model it, and score the DUT response.
    task automatic run_bit(input bit valid, input bit b);
        exp_t e, got;
        int   mask;
        bit_valid = valid;
        Binary_In = b;
        e.pulse = 1'b0;
        if (valid && m_active && m_rem > 0) begin
            m_hist = ((m_hist << 1) | int'(b)) & ((1 << PAT_W) - 1);
            m_fill = (m_fill < PAT_W) ? m_fill + 1 : PAT_W;
            m_rem--;
            mask = (1 << m_len) - 1;
            if (m_fill >= m_len && (m_hist & mask) == (m_pat & mask)) begin
                e.pulse = 1'b1;
                if (m_count == MAX_M) m_ovf = 1'b1; else m_count++;
                if (m_sat_count == MAX_S) m_sat_ovf = 1'b1; else m_sat_count++;
            end
            if (m_rem == 0 || (m_limit != 0 && m_count == m_limit)) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        e.count = m_count; e.ovf = m_ovf;
        e.sat_count = m_sat_count; e.sat_ovf = m_sat_ovf;
        e.busy = m_active; e.done = m_done;
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        bit_valid = 1'b0;
        got = sb.pop_front();
        checks++;
        if (match_pulse !== got.pulse) begin
            errors++;
            $display("FAIL match_pulse: got %b required %b", match_pulse, got.pulse);
        end
        checks++;
        if (match_count !== CNT_W'(got.count) || overflow !== got.ovf) begin
            errors++;
            $display("FAIL count: got %0d/ovf %b required %0d/ovf %b", match_count, overflow, got.count, got.ovf);
        end
        checks++;
        if (s_match_pulse !== got.pulse || s_match_count !== SAT_W'(got.sat_count) || s_overflow !== got.sat_ovf) begin
            errors++;
            $display("FAIL sat_count: got pulse %b count %0d ovf %b required %b %0d %b",
                     s_match_pulse, s_match_count, s_overflow, got.pulse, got.sat_count, got.sat_ovf);
        end
        checks++;
        if (busy !== got.busy || done !== got.done) begin
            errors++;
            $display("FAIL busy_done: got %b/%b required %b/%b", busy, done, got.busy, got.done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || match_pulse !== 1'b0 ||
            match_count !== '0 || overflow !== 1'b0 || s_cfg_ready !== 1'b1 || s_match_count !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b pulse=%b count=%0d ovf=%b required 1 0 0 0 0 0",
                     cfg_ready, busy, done, match_pulse, match_count, overflow);
        end
        RST = 1'b1;
        do_cfg(4'b0011, 2, 6, 0);
        @(negedge CLK);
        start_session();
        run_bit(1'b1, 1'b1);
        run_bit(1'b1, 1'b1);
        // asynchronous reset in the middle of the session
        RST = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1 || match_count !== '0 ||
            match_pulse !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b ready=%b count=%0d pulse=%b ovf=%b required 0 0 1 0 0 0",
                     busy, done, cfg_ready, match_count, match_pulse, overflow);
        end
        #1 RST = 1'b1;
        m_active = 1'b0; m_done = 1'b0;
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic_match();
        bit stream [7] = '{1, 0, 1, 1, 0, 1, 1};
        do_cfg(4'b1011, 4, 7, 0);
        @(negedge CLK);
        start_session();
        foreach (stream[i]) run_bit(1'b1, stream[i]);
        checks++;
        if (done !== 1'b1 || match_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL basic_result: done=%b count=%0d required 1 2", done, match_count);
        end
    endtask

    task automatic test_overlap_gaps();
        bit vld [9] = '{1, 0, 1, 1, 0, 0, 1, 0, 1};
        do_cfg(4'b0011, 2, 5, 0);
        @(negedge CLK);
        start_session();
        foreach (vld[i]) run_bit(vld[i], 1'b1);
        checks++;
        if (done !== 1'b1 || match_count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL overlap_result: done=%b count=%0d required 1 4", done, match_count);
        end
    endtask

    task automatic test_saturation();
        // length 0 is treated as a one-bit pattern
        do_cfg(4'b0001, 0, 6, 0);
        @(negedge CLK);
        start_session();
        repeat (6) run_bit(1'b1, 1'b1);
        checks++;
        if (s_match_count !== SAT_W'(3) || s_overflow !== 1'b1 || match_count !== CNT_W'(6)) begin
            errors++;
            $display("FAIL saturation: sat count %0d ovf %b main %0d required 3 1 6",
                     s_match_count, s_overflow, match_count);
        end
    endtask

    task automatic test_len_clamp();
        bit stream [5] = '{0, 1, 1, 0, 1};
        do_cfg(4'b0110, 7, 5, 0);
        @(negedge CLK);
        start_session();
        foreach (stream[i]) run_bit(1'b1, stream[i]);
    endtask

    task automatic test_zero_bits();
        do_cfg(4'b0001, 1, 0, 0);
        @(negedge CLK);
        start_session();
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || match_count !== '0) begin
            errors++;
            $display("FAIL zero_bits: busy=%b done=%b count=%0d required 0 1 0", busy, done, match_count);
        end
        // config and start offered together: config wins, no session starts
        cfg_valid = 1'b1;
        cfg_bits  = LEN_W'(3);
        start     = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cfg_valid = 1'b0;
        start     = 1'b0;
        repeat (2) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL cfg_and_start: busy=%b done=%b ready=%b required 0 0 1", busy, done, cfg_ready);
            end
            @(negedge CLK);
        end
    endtask

`ifdef PMC_MATCH_LIMIT_EN
    task automatic test_match_limit();
        do_cfg(4'b0011, 2, 5, 2);
        @(negedge CLK);
        start_session();
        repeat (5) run_bit(1'b1, 1'b1);
        checks++;
        if (done !== 1'b1 || match_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL match_limit: done=%b count=%0d required 1 2", done, match_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_match();
        test_overlap_gaps();
        test_saturation();
        test_len_clamp();
        test_zero_bits();
`ifdef PMC_MATCH_LIMIT_EN
        test_match_limit();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
